// File: rtl/cpu_stream_arbiter.sv
// cpu_stream_arbiter: merges the single-cycle data_vld/data pulses of N_SRC
// cpu instances into one valid/ready stream. Every source has a small FIFO,
// and a round-robin scheduler drains the FIFOs into a registered output
// tagged with the source index.
// Optional feature: define CPU_STREAM_ARBITER_STATS_EN to add the per-source
// stat_cnt (accepted words) and stat_drop (dropped words) counters.
module cpu_stream_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int SRC_W      = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        in_vld,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
`ifdef CPU_STREAM_ARBITER_STATS_EN
  output logic [N_SRC*32-1:0]     stat_cnt,
  output logic [N_SRC*32-1:0]     stat_drop,
`endif
  output logic [N_SRC-1:0]        overflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  typedef enum logic {ST_EMPTY, ST_HOLD} arbState_t;

  arbState_t         r_state;
  arbState_t         w_nextState;
  logic [DATA_W-1:0] r_outData;
  logic [SRC_W-1:0]  r_outSrc;
  logic [SRC_W-1:0]  r_rrLast;

  logic [N_SRC-1:0]  w_empty;
  logic [N_SRC-1:0]  w_full;
  logic [N_SRC-1:0]  w_pop;
  logic [N_SRC-1:0]  w_push;
  logic [N_SRC-1:0]  w_drop;
  logic [N_SRC-1:0]  w_overflow;
  logic [DATA_W-1:0] w_fifoHead [N_SRC];

  logic              w_load;
  logic              w_popEn;
  logic              w_anyValid;
  logic [SRC_W-1:0]  w_grant;
  logic [DATA_W-1:0] w_head;

  // Round-robin search: first non-empty FIFO after the last granted source,
  // based on occupancy before this edge's pushes.
  always_comb begin
    logic [SRC_W-1:0] cand;
    cand       = '0;
    w_grant    = '0;
    w_anyValid = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = SRC_W'((int'(r_rrLast) + k) % N_SRC);
      if (!w_empty[cand]) begin
        w_grant    = cand;
        w_anyValid = 1'b1;
      end
    end
  end

  assign w_head  = w_fifoHead[w_grant];
  assign w_popEn = w_load && w_anyValid;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fifo
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic              r_ovf;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    assign w_empty[gi]    = (r_wrPtr == r_rdPtr);
    assign w_full[gi]     = (r_wrPtr[ADDR_W] != r_rdPtr[ADDR_W]) &&
                            (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]);
    assign w_pop[gi]      = w_popEn && (w_grant == SRC_W'(gi));
    assign w_push[gi]     = in_vld[gi] && (!w_full[gi] || w_pop[gi]);
    assign w_drop[gi]     = in_vld[gi] && !w_push[gi];
    assign w_fifoHead[gi] = r_mem[r_rdPtr[ADDR_W-1:0]];
    assign w_overflow[gi] = r_ovf;

    // Pointer bookkeeping and the sticky drop flag; reset empties the FIFO.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_push[gi]) r_wrPtr <= r_wrPtr + PTR_W'(1);
        if (w_pop[gi])  r_rdPtr <= r_rdPtr + PTR_W'(1);
        if (w_drop[gi]) r_ovf   <= 1'b1;
      end
    end

    // Storage array, written only when a push is accepted.
    always_ff @(posedge clk) begin
      if (!rst && w_push[gi]) r_mem[r_wrPtr[ADDR_W-1:0]] <= in_data[gi*DATA_W +: DATA_W];
    end

`ifdef CPU_STREAM_ARBITER_STATS_EN
    logic [31:0] r_statCnt;
    logic [31:0] r_statDrop;

    assign stat_cnt[gi*32 +: 32]  = r_statCnt;
    assign stat_drop[gi*32 +: 32] = r_statDrop;

    // Saturating counters of accepted output words and dropped input words.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_statCnt  <= '0;
        r_statDrop <= '0;
      end else begin
        if ((r_state == ST_HOLD) && out_rdy && (r_outSrc == SRC_W'(gi)) && (r_statCnt != 32'hFFFF_FFFF))
          r_statCnt <= r_statCnt + 32'd1;
        if (w_drop[gi] && (r_statDrop != 32'hFFFF_FFFF))
          r_statDrop <= r_statDrop + 32'd1;
      end
    end
`endif
  end

  // Output register state: load when empty or when the held word is taken.
  always_comb begin
    w_nextState = r_state;
    w_load      = (r_state == ST_EMPTY) || out_rdy;
    if (w_load) w_nextState = w_anyValid ? ST_HOLD : ST_EMPTY;
  end

  // State register for the output stage.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_nextState;
  end

  // Output data/tag register and round-robin pointer, updated on each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outData <= '0;
      r_outSrc  <= '0;
      r_rrLast  <= SRC_W'(N_SRC - 1);
    end else if (w_popEn) begin
      r_outData <= w_head;
      r_outSrc  <= w_grant;
      r_rrLast  <= w_grant;
    end
  end

  assign out_vld  = (r_state == ST_HOLD);
  assign out_data = r_outData;
  assign out_src  = r_outSrc;
  assign overflow = w_overflow;

endmodule

// File: tb/tb_cpu_stream_arbiter.sv
// Directed testbench for cpu_stream_arbiter (N_SRC=4, DATA_W=64, FIFO_DEPTH=4).
module tb_cpu_stream_arbiter;
  localparam int N_SRC  = 4;
  localparam int DATA_W = 64;
  localparam int SRC_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_SRC-1:0]        in_vld;
  logic [N_SRC*DATA_W-1:0] in_data;
  logic                    out_vld;
  logic                    out_rdy;
  logic [DATA_W-1:0]       out_data;
  logic [SRC_W-1:0]        out_src;
  logic [N_SRC-1:0]        overflow;
`ifdef CPU_STREAM_ARBITER_STATS_EN
  logic [N_SRC*32-1:0]     stat_cnt;
  logic [N_SRC*32-1:0]     stat_drop;
`endif

  int nChecks = 0;
  int nPass   = 0;

  cpu_stream_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_vld(in_vld),
    .in_data(in_data),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_data(out_data),
    .out_src(out_src),
`ifdef CPU_STREAM_ARBITER_STATS_EN
    .stat_cnt(stat_cnt),
    .stat_drop(stat_drop),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_vld = '0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_vld = '0; in_data = '0; out_rdy = 1'b1;
    tick; tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL reset_vld: got %0b expected 0", out_vld); else nPass++;
    nChecks++; if (out_data !== 64'd0) $display("[TB] FAIL reset_data: got %h expected 0", out_data); else nPass++;
    nChecks++; if (out_src !== 2'd0) $display("[TB] FAIL reset_src: got %0d expected 0", out_src); else nPass++;
    nChecks++; if (overflow !== 4'b0) $display("[TB] FAIL reset_overflow: got %b expected 0000", overflow); else nPass++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL idle_vld cycle %0d: got %0b expected 0", i, out_vld); else nPass++;
      nChecks++; if (out_data !== 64'd0) $display("[TB] FAIL idle_data cycle %0d: got %h expected 0", i, out_data); else nPass++;
      nChecks++; if (overflow !== 4'b0) $display("[TB] FAIL idle_overflow cycle %0d: got %b expected 0000", i, overflow); else nPass++;
    end
  endtask

  task automatic test_single_word;
    out_rdy = 1'b1;
    in_data = '0;
    in_data[2*DATA_W +: DATA_W] = 64'h5821657736338717;
    in_vld = 4'b0100;
    tick;
    in_vld = '0;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL single_latency: got vld %0b expected 0", out_vld); else nPass++;
    tick;
    nChecks++; if (out_vld !== 1'b1) $display("[TB] FAIL single_vld: got %0b expected 1", out_vld); else nPass++;
    nChecks++; if (out_src !== 2'd2) $display("[TB] FAIL single_src: got %0d expected 2", out_src); else nPass++;
    nChecks++; if (out_data !== 64'h5821657736338717) $display("[TB] FAIL single_data: got %h expected 5821657736338717", out_data); else nPass++;
    tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL single_drain: got vld %0b expected 0", out_vld); else nPass++;
  endtask

  task automatic test_round_robin;
    logic [SRC_W-1:0] expSrc;
    do_reset;
    out_rdy = 1'b1;
    for (int i = 0; i < N_SRC; i++) in_data[i*DATA_W +: DATA_W] = 64'hA0 + 64'(i);
    in_vld = 4'b1111;
    tick;
    in_vld = '0;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL rr_latency: got vld %0b expected 0", out_vld); else nPass++;
    for (int i = 0; i < N_SRC; i++) begin
      tick;
      expSrc = SRC_W'(i);
      nChecks++; if (out_vld !== 1'b1) $display("[TB] FAIL rr_vld %0d: got %0b expected 1", i, out_vld); else nPass++;
      nChecks++; if (out_src !== expSrc) $display("[TB] FAIL rr_src %0d: got %0d expected %0d", i, out_src, expSrc); else nPass++;
      nChecks++; if (out_data !== 64'hA0 + 64'(i)) $display("[TB] FAIL rr_data %0d: got %h expected %h", i, out_data, 64'hA0 + 64'(i)); else nPass++;
    end
    tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL rr_drain: got vld %0b expected 0", out_vld); else nPass++;
    for (int i = 0; i < N_SRC; i++) in_data[i*DATA_W +: DATA_W] = 64'hD0 + 64'(i);
    in_vld = 4'b0101;
    tick;
    in_vld = '0;
    for (int j = 0; j < 2; j++) begin
      tick;
      expSrc = (j == 0) ? 2'd0 : 2'd2;
      nChecks++; if (out_src !== expSrc) $display("[TB] FAIL rr2_src %0d: got %0d expected %0d", j, out_src, expSrc); else nPass++;
      nChecks++; if (out_data !== 64'hD0 + 64'(expSrc)) $display("[TB] FAIL rr2_data %0d: got %h expected %h", j, out_data, 64'hD0 + 64'(expSrc)); else nPass++;
    end
    tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL rr2_drain: got vld %0b expected 0", out_vld); else nPass++;
  endtask

  task automatic test_backpressure;
    do_reset;
    out_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_data[1*DATA_W +: DATA_W] = 64'(i);
      in_vld = 4'b0010;
      tick;
    end
    in_vld = '0;
    nChecks++; if (out_vld !== 1'b1) $display("[TB] FAIL bp_vld: got %0b expected 1", out_vld); else nPass++;
    nChecks++; if (out_data !== 64'd1) $display("[TB] FAIL bp_data: got %h expected 1", out_data); else nPass++;
    nChecks++; if (out_src !== 2'd1) $display("[TB] FAIL bp_src: got %0d expected 1", out_src); else nPass++;
    nChecks++; if (overflow !== 4'b0010) $display("[TB] FAIL bp_overflow: got %b expected 0010", overflow); else nPass++;
    tick; tick;
    nChecks++; if (out_data !== 64'd1) $display("[TB] FAIL bp_stable: got %h expected 1", out_data); else nPass++;
    out_rdy = 1'b1;
    for (int d = 2; d <= 5; d++) begin
      tick;
      nChecks++; if (out_vld !== 1'b1) $display("[TB] FAIL bp_drain_vld %0d: got %0b expected 1", d, out_vld); else nPass++;
      nChecks++; if (out_data !== 64'(d)) $display("[TB] FAIL bp_drain_data: got %h expected %h", out_data, 64'(d)); else nPass++;
      nChecks++; if (out_src !== 2'd1) $display("[TB] FAIL bp_drain_src %0d: got %0d expected 1", d, out_src); else nPass++;
    end
    tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL bp_empty: got vld %0b expected 0", out_vld); else nPass++;
    nChecks++; if (overflow !== 4'b0010) $display("[TB] FAIL bp_sticky: got %b expected 0010", overflow); else nPass++;
  endtask

  task automatic test_full_pop;
    do_reset;
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data[0 +: DATA_W] = 64'h10 + 64'(i);
      in_vld = 4'b0001;
      tick;
    end
    in_vld = '0;
    nChecks++; if (out_data !== 64'h10) $display("[TB] FAIL fp_hold: got %h expected 10", out_data); else nPass++;
    nChecks++; if (overflow !== 4'b0) $display("[TB] FAIL fp_prefill_ovf: got %b expected 0000", overflow); else nPass++;
    in_data[0 +: DATA_W] = 64'h15;
    in_vld = 4'b0001;
    out_rdy = 1'b1;
    tick;
    in_vld = '0;
    nChecks++; if (out_data !== 64'h11) $display("[TB] FAIL fp_pop: got %h expected 11", out_data); else nPass++;
    nChecks++; if (overflow !== 4'b0) $display("[TB] FAIL fp_overflow: got %b expected 0000", overflow); else nPass++;
    for (int d = 'h12; d <= 'h15; d++) begin
      tick;
      nChecks++; if (out_data !== 64'(d)) $display("[TB] FAIL fp_drain: got %h expected %h", out_data, 64'(d)); else nPass++;
    end
    tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL fp_empty: got vld %0b expected 0", out_vld); else nPass++;
  endtask

  task automatic test_mid_reset;
    do_reset;
    out_rdy = 1'b0;
    for (int i = 0; i < N_SRC; i++) in_data[i*DATA_W +: DATA_W] = 64'hB0 + 64'(i);
    in_vld = 4'b0111;
    tick;
    in_vld = 4'b0010;
    for (int i = 0; i < 5; i++) tick;
    in_vld = '0;
    nChecks++; if (out_vld !== 1'b1) $display("[TB] FAIL mr_pre_vld: got %0b expected 1", out_vld); else nPass++;
    nChecks++; if (out_src !== 2'd0) $display("[TB] FAIL mr_pre_src: got %0d expected 0", out_src); else nPass++;
    nChecks++; if (overflow !== 4'b0010) $display("[TB] FAIL mr_pre_ovf: got %b expected 0010", overflow); else nPass++;
    rst = 1'b1;
    in_vld = 4'b1111;
    tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL mr_vld: got %0b expected 0", out_vld); else nPass++;
    nChecks++; if (overflow !== 4'b0) $display("[TB] FAIL mr_overflow: got %b expected 0000", overflow); else nPass++;
    nChecks++; if (out_data !== 64'd0) $display("[TB] FAIL mr_data: got %h expected 0", out_data); else nPass++;
    rst = 1'b0;
    in_vld = '0;
    out_rdy = 1'b1;
    tick; tick;
    nChecks++; if (out_vld !== 1'b0) $display("[TB] FAIL mr_fifos_empty: got vld %0b expected 0", out_vld); else nPass++;
    in_data[3*DATA_W +: DATA_W] = 64'hC3;
    in_vld = 4'b1000;
    tick;
    in_vld = '0;
    tick;
    nChecks++; if (out_vld !== 1'b1) $display("[TB] FAIL mr_post_vld: got %0b expected 1", out_vld); else nPass++;
    nChecks++; if (out_src !== 2'd3) $display("[TB] FAIL mr_post_src: got %0d expected 3", out_src); else nPass++;
    nChecks++; if (out_data !== 64'hC3) $display("[TB] FAIL mr_post_data: got %h expected c3", out_data); else nPass++;
  endtask

  // Sequence the scenarios and report.
  initial begin
    test_reset;
    test_single_word;
    test_round_robin;
    test_backpressure;
    test_full_pop;
    test_mid_reset;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
